// File: rtl/show_uart_pkg.sv
// Shared types and constants for the debug-frame UART transmitter.
package show_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [4:0] MAX_LEN   = 5'd16;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 single-byte shifter. ready is also high in the last STOP cycle so that
// a following byte can start with no idle gap between characters.
module uart_byte_tx
  import show_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  state_t      state, state_nxt;
  logic [15:0] baud;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        term, load;

  assign term = (baud == 16'(CLKS_PER_BIT - 1));
  assign load = ready && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = START;
      START:   if (term) state_nxt = DATA;
      DATA:    if (term && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (term) state_nxt = start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx    = 1'b1;
    ready = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      STOP:    ready = term;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || term) baud <= '0;
      else                       baud <= baud + 16'd1;
      if (state != DATA) bit_cnt <= '0;
      else if (term)     bit_cnt <= bit_cnt + 3'd1;
      if (load)                       shreg <= data;
      else if (state == DATA && term) shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/show_uart_tx.sv
// Debug-frame UART transmitter: snapshots a frame on send and emits it MSB byte
// first as 8N1. Define SHOW_UART_HDR_EN to prefix each frame with A5 and length.
module show_uart_tx
  import show_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BYTES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     send,
  input  logic [8*FRAME_BYTES-1:0] tx_show,
  input  logic [4:0]               show_len,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               drop_cnt
);

  logic [FRAME_BYTES-1:0][7:0] frame;
  logic [4:0] len_in, rem;
  logic [3:0] idx, first_idx;
  logic       hdr_pend, accept, drop, more, byte_ready, byte_start;
  logic [7:0] byte_data;

  assign len_in     = clamp_len(show_len);
  assign first_idx  = 4'(len_in - 5'd1);
  // The done cycle still belongs to the previous frame, so sends there drop.
  assign accept     = send && (show_len != '0) && !busy && !done;
  assign drop       = send && (show_len != '0) && (busy || done);
  assign more       = (rem != '0);
  assign byte_start = accept || (busy && byte_ready && more);

`ifdef SHOW_UART_HDR_EN
  logic [4:0] len_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r    <= '0;
      hdr_pend <= 1'b0;
    end else if (accept) begin
      len_r    <= len_in;
      hdr_pend <= 1'b1;
    end else if (busy && byte_ready && more) begin
      hdr_pend <= 1'b0;
    end
  end

  always_comb begin
    byte_data = frame[idx];
    if (!busy)         byte_data = SYNC_BYTE;
    else if (hdr_pend) byte_data = {3'b000, len_r};
  end
`else
  logic [FRAME_BYTES-1:0][7:0] in_bytes;

  assign in_bytes = tx_show;
  assign hdr_pend = 1'b0;

  // First byte comes straight from the inputs since the buffer loads this cycle.
  always_comb begin
    byte_data = frame[idx];
    if (!busy) byte_data = in_bytes[first_idx];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame    <= '0;
      idx      <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done <= busy && byte_ready && !more;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (accept) begin
        frame <= tx_show;
        busy  <= 1'b1;
`ifdef SHOW_UART_HDR_EN
        idx <= first_idx;
        rem <= len_in + 5'd1;
`else
        idx <= first_idx - 4'd1;
        rem <= len_in - 5'd1;
`endif
      end else if (busy && byte_ready) begin
        if (more) begin
          rem <= rem - 5'd1;
          if (!hdr_pend) idx <= idx - 4'd1;
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .ready (byte_ready)
  );

endmodule

// File: doc/show_uart_tx.md
Name: show_uart_tx

Overview:
Serialises the 128-bit debug frame (tx_show) and its byte count (show_len), which the top-level demo logic produces, onto a UART line for the host monitor. It sits directly downstream of the top-level debug-frame generator. A one-cycle send pulse snapshots the frame. The block then emits show_len bytes, most-significant valid byte first, as 8N1 characters. Frames that arrive while a transmission is in progress are dropped and counted.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
FRAME_BYTES, 16, capacity of the frame buffer in bytes; tx_show width = 8*FRAME_BYTES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
send  input  1  single-cycle request to snapshot and transmit the current frame
tx_show  input  128  frame data; valid bytes are right-aligned (byte k = tx_show[8k+7:8k])
show_len  input  5  number of valid bytes, 0..16
tx  output  1  UART serial out; idle high
busy  output  1  high from snapshot until the last stop bit ends
done  output  1  one-cycle pulse after the final stop bit of a frame
drop_cnt  output  8  number of frames dropped because send arrived while busy; saturates at 255

Behaviour:
- Reset (reset=0, asynchronous) values: tx=1, busy=0, done=0, drop_cnt=0, state=IDLE, counters=0, frame buffer=0. Reset mid-frame aborts immediately; tx returns high.
- Snapshot: in IDLE, send=1 with show_len!=0 latches tx_show and len=min(show_len,16). busy rises the next cycle.
- Zero-length frames: send with show_len=0 is ignored and not counted as a drop.
- Drops: send while busy (including the done cycle) is ignored and drop_cnt increments, saturating at 255.
- Byte order: byte index len-1 is sent first, down to byte 0. Bits within a byte go LSB first.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on an accepted send.
  - START drives tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA drives 8 bits, each held CLKS_PER_BIT cycles, then goes to STOP.
  - STOP drives tx=1 for CLKS_PER_BIT cycles. If bytes remain, it goes to START with the byte index decremented. Otherwise it goes to IDLE and pulses done.
- Counters:
  - Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1 and wraps at terminal count.
  - Bit counter: 3-bit.
  - Byte index: 4-bit.
- Timing:
  - tx first goes low the cycle after send is accepted.
  - Frame duration is exactly len*10*CLKS_PER_BIT cycles of busy=1.
  - done asserts in the first cycle of IDLE, and busy=0 in that same cycle.
  - A send in the cycle after done is accepted.
- The tx_show/show_len inputs may change every cycle. Only the snapshot value matters.

Optional Feature:
SHOW_UART_HDR_EN
- Defined: each frame is prefixed by two header bytes, 0xA5 followed by {3'b0,len}, before the payload. busy time becomes (len+2)*10*CLKS_PER_BIT cycles. Zero-length sends are still ignored.
- Undefined: payload bytes only, exactly as described in Behaviour.

Decomposition:
- Package show_uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - SYNC_BYTE=8'hA5
  - MAX_LEN=5'd16
- One sub-module, uart_byte_tx, is natural. It is the 8N1 single-byte shifter:
  - inputs: start, data[7:0]
  - outputs: tx, ready
  - parameter: CLKS_PER_BIT
- The top of show_uart_tx holds the frame buffer, byte index, drop counter and header sequencing.

Test Plan:
- CLKS_PER_BIT=4, tx_show=128'h...0000_1234, show_len=2, send pulse -> tx sends 0x12 then 0x34 (start 0, LSB first, stop 1). busy is high for exactly 80 cycles, then done pulses once.
- Mid-frame send with show_len=4 -> frame ignored, drop_cnt 0->1, transmitted bytes unchanged. 300 such drops -> drop_cnt holds at 255.
- show_len=5'd20, tx_show all-0xFF -> exactly 16 bytes of 0xFF sent, busy=640 cycles. show_len=0 send -> busy stays 0, drop_cnt unchanged.
- reset driven low in the middle of the 3rd byte -> tx=1 and busy=0 immediately (asynchronous). After reset release, a new send transmits from the first byte.
- Back-to-back frames: send asserted in the done+1 cycle -> accepted, tx low on the next cycle, no gap errors.
- SHOW_UART_HDR_EN defined, show_len=1, byte0=0x3C -> bytes A5, 01, 3C sent; busy=120 cycles at CLKS_PER_BIT=4.
